// File: rtl/seq_shift_add_multiplier_if.sv
// ============================================================================
// seq_shift_add_multiplier_if : Start/Busy/Done handshake and operand bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface seq_shift_add_multiplier_if #(
  parameter int N = 4
);
  logic           start_i;
  logic           signed_mode_i;
  logic [N-1:0]   m_i;
  logic [N-1:0]   q_i;
  logic           busy_o;
  logic           done_o;
  logic [2*N-1:0] p_o;

  modport master (
    output start_i, signed_mode_i, m_i, q_i,
    input  busy_o, done_o, p_o
  );

  modport slave (
    input  start_i, signed_mode_i, m_i, q_i,
    output busy_o, done_o, p_o
  );
endinterface

`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
// ============================================================================
// seq_shift_add_multiplier : N x N shift-add multiplier, one partial product/clk
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_shift_add_multiplier_if.slave   bus
);

  localparam int             PW   = 2 * N;
  localparam int             CW   = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mc_q, mc_d;
  logic [N-1:0]   mq_q, mq_d;
  logic           neg_q, neg_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;

  logic [N-1:0]   m_mag, q_mag;
  logic [N:0]     sum;

  // Magnitude of -2^(N-1) wraps to 2^(N-1), which is still correct as unsigned.
  assign m_mag = (bus.signed_mode_i && bus.m_i[N-1]) ? (~bus.m_i + N'(1)) : bus.m_i;
  assign q_mag = (bus.signed_mode_i && bus.q_i[N-1]) ? (~bus.q_i + N'(1)) : bus.q_i;

  // Shifted accumulator: add into the upper half, then shift right one bit.
  assign sum = {1'b0, acc_q[PW-1:N]} + {1'b0, (mq_q[0] ? mc_q : {N{1'b0}})};

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    mq_d    = mq_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          mc_d    = m_mag;
          mq_d    = q_mag;
          neg_d   = bus.signed_mode_i & (bus.m_i[N-1] ^ bus.q_i[N-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = {sum, acc_q[N-1:1]};
        mq_d  = mq_q >> 1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FINISH: begin
        p_d     = neg_q ? (~acc_q + PW'(1)) : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mc_q    <= '0;
      mq_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      mq_q    <= mq_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = done_q;
  assign bus.p_o    = p_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
// ============================================================================
// tb_seq_shift_add_multiplier : scoreboard bench for N=4 and N=8 instances
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_shift_add_multiplier_if #(.N(4)) if4 ();
  seq_shift_add_multiplier_if #(.N(8)) if8 ();

  seq_shift_add_multiplier #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  seq_shift_add_multiplier #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp4[$];
  logic [15:0] exp8[$];
  logic [15:0] last_p4 = '0;
  logic [15:0] last_p8 = '0;

  // Reference: plain integer multiply of the operands' numeric values.
  function automatic logic [15:0] model(int n, logic [7:0] m, logic [7:0] q, logic s);
    longint one = 1;
    longint a, b, r;
    a = longint'(m);
    b = longint'(q);
    if (s && m[n-1]) a = a - (one << n);
    if (s && q[n-1]) b = b - (one << n);
    r = a * b;
    return 16'(r & ((one << (2 * n)) - 1));
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int n, logic st, logic [7:0] m, logic [7:0] q, logic s);
    if (n == 4) begin
      if4.start_i = st; if4.m_i = m[3:0]; if4.q_i = q[3:0]; if4.signed_mode_i = s;
    end else begin
      if8.start_i = st; if8.m_i = m; if8.q_i = q; if8.signed_mode_i = s;
    end
  endtask

  function automatic logic get_done(int n);
    return (n == 4) ? if4.done_o : if8.done_o;
  endfunction

  function automatic logic get_busy(int n);
    return (n == 4) ? if4.busy_o : if8.busy_o;
  endfunction

  // Issue one operation from an idle cycle and wait for its Done.
  task automatic run_op(int n, logic [7:0] m, logic [7:0] q, logic s, logic [15:0] exp);
    int cyc;
    bit seen;
    drive(n, 1'b1, m, q, s);
    if (n == 4) exp4.push_back(exp); else exp8.push_back(exp);
    @(posedge clk); #1;
    drive(n, 1'b0, ~m, ~q, ~s);
    check($sformatf("n%0d busy after start", n), {15'd0, get_busy(n)}, 16'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 4 * n) begin
      @(posedge clk); #1;
      cyc++;
      if (get_done(n)) seen = 1'b1;
    end
    checks++;
    if (!seen || cyc != n + 1) begin
      errors++;
      $display("FAIL n%0d latency: got %0d cycles (seen=%0d) expected %0d", n, cyc, seen, n + 1);
    end
    check($sformatf("n%0d busy in done cycle", n), {15'd0, get_busy(n)}, 16'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_p4 = '0;
    end else begin
      if (if4.done_o) begin
        if (exp4.size() == 0) begin
          checks++; errors++;
          $display("FAIL n4 unexpected done: got p=%h expected no done", if4.p_o);
        end else begin
          check("n4 product", {8'd0, if4.p_o}, exp4.pop_front());
        end
        check("n4 done while busy", {15'd0, if4.busy_o}, 16'd0);
        last_p4 = {8'd0, if4.p_o};
      end else begin
        check("n4 p held", {8'd0, if4.p_o}, last_p4);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      last_p8 = '0;
    end else begin
      if (if8.done_o) begin
        if (exp8.size() == 0) begin
          checks++; errors++;
          $display("FAIL n8 unexpected done: got p=%h expected no done", if8.p_o);
        end else begin
          check("n8 product", if8.p_o, exp8.pop_front());
        end
        check("n8 done while busy", {15'd0, if8.busy_o}, 16'd0);
        last_p8 = if8.p_o;
      end else begin
        check("n8 p held", if8.p_o, last_p8);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m, q;
    logic       s;
    drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("n4 reset busy", {15'd0, if4.busy_o}, 16'd0);
    check("n4 reset done", {15'd0, if4.done_o}, 16'd0);
    check("n4 reset p",    {8'd0, if4.p_o},     16'd0);
    check("n8 reset busy", {15'd0, if8.busy_o}, 16'd0);
    check("n8 reset done", {15'd0, if8.done_o}, 16'd0);
    check("n8 reset p",    if8.p_o,             16'd0);

    // Directed N=4 cases with hand-derived products.
    run_op(4, 8'hF, 8'hF, 1'b0, 16'h00E1);
    run_op(4, 8'h8, 8'h8, 1'b1, 16'h0040);
    run_op(4, 8'h7, 8'h8, 1'b1, 16'h00C8);
    run_op(4, 8'hF, 8'h1, 1'b1, 16'h00FF);
    run_op(4, 8'h0, 8'h9, 1'b1, 16'h0000);
    run_op(4, 8'h1, 8'h8, 1'b0, 16'h0008);

    // Start held high with changing operands: only the first pair counts.
    drive(4, 1'b1, 8'h5, 8'h6, 1'b0);
    exp4.push_back(16'h001E);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      drive(4, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
    end
    drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    check("n4 held-start done", {15'd0, if4.done_o}, 16'd1);

    // Back-to-back: Start issued in the Done cycle.
    run_op(4, 8'h3, 8'h5, 1'b0, 16'h000F);

    // Reset in the second RUN cycle aborts without a Done.
    drive(4, 1'b1, 8'hF, 8'hF, 1'b0);
    @(posedge clk); #1;
    drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("n4 abort busy", {15'd0, if4.busy_o}, 16'd0);
    check("n4 abort done", {15'd0, if4.done_o}, 16'd0);
    check("n4 abort p",    {8'd0, if4.p_o},     16'd0);
    repeat (12) @(posedge clk);
    #1;

    run_op(8, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run_op(8, 8'h80, 8'h7F, 1'b1, 16'hC080);

    for (int i = 0; i < 200; i++) begin
      m = 8'($urandom_range(0, 15));
      q = 8'($urandom_range(0, 15));
      s = 1'($urandom_range(0, 1));
      run_op(4, m, q, s, model(4, m, q, s));
    end
    for (int i = 0; i < 1000; i++) begin
      m = 8'($urandom);
      q = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      run_op(8, m, q, s, model(8, m, q, s));
    end

    repeat (3) @(posedge clk);
    #1;
    check("n4 pending results", 16'(exp4.size()), 16'd0);
    check("n8 pending results", 16'(exp8.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised sequential N x N multiplier. It replaces the combinational 4x4 array multiplier wherever area matters more than latency.
- Accumulates one partial product per clock using a single N+1-bit adder. Costs N+1 cycles instead of N-1 ripple adders.
- Adds a signed (two's-complement) mode and a Start/Busy/Done handshake.
- Sits beside the datapath units that consume 2N-bit products.

Parameters:
- N, 4, operand width in bits (N >= 2); product width is 2N.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- SignedMode  input  1  1 = operands two's-complement, 0 = unsigned; sampled with Start.
- m  input  N  multiplicand; sampled with Start.
- q  input  N  multiplier; sampled with Start.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse; p valid and new.
- p  output  2N  product register; holds the last result until the next Done.

Behaviour:
- Reset: one clock, synchronous, active-high. Fixed decision.
  - Reset high at a rising edge forces state=IDLE, Busy=0, Done=0, p=0, and clears counter and accumulator.
  - Reset overrides everything, including mid-operation; the aborted operation produces no Done.
- State machine: IDLE, RUN, FINISH.
- IDLE:
  - Busy=0.
  - Start=1 at edge t:
    - Latch mc = |m| and mq = |q| (magnitudes when SignedMode=1, raw values otherwise).
    - Latch neg = SignedMode & (m[N-1] ^ q[N-1]).
    - acc=0, cnt=0; go to RUN.
  - Start=0: stay.
- RUN (edges t+1 .. t+N):
  - Each edge: if mq[0], acc += mc << cnt (2N-bit add; a shifted-accumulator implementation is acceptable if results match).
  - Each edge: mq >>= 1, cnt += 1.
  - After N edges go to FINISH; cnt wraps to 0.
  - Busy=1.
- FINISH (edge t+N+1):
  - p <= neg ? -acc : acc (2N-bit two's complement).
  - Done=1 for exactly the following cycle; go to IDLE.
  - Busy=1 in FINISH, 0 once back in IDLE.
- Latency: Done is visible N+1 cycles after the Start-accepting edge. Throughput is one result per N+2 cycles minimum.
- Back-to-back: Start high during the Done cycle (state IDLE) is accepted.
- Start while Busy=1 is ignored and not queued. Operand and SignedMode changes while Busy have no effect.
- Magnitude of -2^(N-1) is 2^(N-1) and fits in N unsigned bits. The product magnitude is at most 2^(2N-2), so the signed result always fits 2N bits.
- Zero operand in either mode: p=0; neg is ignored (−0 = 0).
- Done is never high while Busy=1 in RUN. p changes only on the Done-producing edge or on reset.

Test Plan:
- N=4 unsigned: Start with m=4'hF, q=4'hF, SignedMode=0 -> Busy=1 for 5 cycles; Done after 5 cycles; p=8'hE1 (225).
- N=4 signed: m=4'h8, q=4'h8 (-8 x -8) -> p=8'h40 (64). Then m=4'h7, q=4'h8 (7 x -8) -> p=8'hC8 (-56). Then m=4'hF, q=4'h1 (-1 x 1) -> p=8'hFF.
- Handshake, N=4:
  - Start held high for the whole operation with changing m/q -> only the first operands are used; p=first product.
  - Start high in the Done cycle with m=3, q=5 -> accepted; next p=8'h0F.
- Reset mid-operation: Reset asserted in the 2nd RUN cycle -> next cycle Busy=0, Done=0, p=0; no Done ever appears for that operation.
- Zero and sign edge cases, N=4: m=0, q=4'h9 with SignedMode=1 -> p=8'h00. m=4'h1, q=4'h8 with SignedMode=0 -> p=8'h08.
- Parameter sweep N=8: 255 x 255 unsigned -> p=16'hFE01. Signed -128 x 127 -> p=16'hC080. Done after 9 cycles. Plus 1000 random operand/mode pairs checked against a behavioural multiply.
